// File: rtl/if_fetch_queue_pkg.sv
// Shared definitions for the instruction-fetch queue: FSM codes, FIFO entry layout and PC helper.
package if_fetch_queue_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  localparam logic [31:0] NOP_INST = 32'h0000_0000;
  localparam int          ENTRY_W  = 96;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc4;
  } fq_entry_t;

  // Wraps modulo 2^32, so 32'hFFFF_FFFC advances to 0.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_fetch_queue_fq_fifo.sv
// Circular-pointer FIFO holding fetched {inst, pc, pc4} entries; flush empties it in one edge.
module fq_fifo
  import if_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    push,
  input  logic                    pop,
  input  logic [ENTRY_W-1:0]      din,
  output logic [ENTRY_W-1:0]      dout,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [ENTRY_W-1:0] mem_q [DEPTH];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only visible once count covers it.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/if_fetch_queue.sv
// Fetch front end: owns the fetch PC, runs the req/ack memory handshake and buffers results for ID.
module if_fetch_queue
  import if_fetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        hold,
  output logic        out_valid,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc4
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [1:0]         state_q, state_d;
  logic [31:0]        fetch_pc_q, fetch_pc_d;
  logic [31:0]        mem_addr_q, mem_addr_d;
  logic [CW-1:0]      count;
  logic [CW-1:0]      count_next;
  logic               full, empty;
  logic               push, pop, fifo_push;
  logic [31:0]        redirect_pc_al, addr_plus4;
  logic [ENTRY_W-1:0] head_bits;
  fq_entry_t          head, push_entry;

  assign redirect_pc_al = redirect_pc & 32'hFFFF_FFFC;
  assign addr_plus4     = pc_plus4(mem_addr_q);
  assign push_entry     = '{inst: mem_rdata, pc: mem_addr_q, pc4: addr_plus4};
  assign head           = head_bits;

  // Redirect wins over both queue ports: the flush clears count on the same edge.
  assign pop        = ~empty & ~hold & ~redirect;
  assign push       = (state_q == ST_BUSY) & mem_ack & ~redirect;
  assign fifo_push  = push & (~full | pop);
  assign count_next = redirect ? '0 : (count + CW'(push) - CW'(pop));

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    mem_addr_d = mem_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (redirect) begin
          fetch_pc_d = redirect_pc_al;
        end else if (count_next < CW'(DEPTH)) begin
          mem_addr_d = fetch_pc_q;
          state_d    = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (redirect) begin
          // An un-acked request cannot be withdrawn; DROP waits it out with mem_addr held.
          fetch_pc_d = redirect_pc_al;
          state_d    = mem_ack ? ST_IDLE : ST_DROP;
        end else if (mem_ack) begin
          fetch_pc_d = addr_plus4;
          if (count_next < CW'(DEPTH)) begin
            mem_addr_d = addr_plus4;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DROP: begin
        if (redirect) fetch_pc_d = redirect_pc_al;
        if (mem_ack)  state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC & 32'hFFFF_FFFC;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  fq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect),
    .push  (fifo_push),
    .pop   (pop),
    .din   (push_entry),
    .dout  (head_bits),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign mem_req   = (state_q == ST_BUSY) || (state_q == ST_DROP);
  assign mem_addr  = mem_addr_q;
  assign out_valid = ~empty;
  assign out_inst  = empty ? NOP_INST : head.inst;
  assign out_pc    = empty ? 32'h0 : head.pc;
  assign out_pc4   = empty ? 32'h0 : head.pc4;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue: variable-latency memory model plus hand-derived expectations.
module tb_if_fetch_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        hold = 1'b0;
  int          lat = 0;
  int          wait_cnt;

  logic        mem_req, mem_ack, out_valid;
  logic [31:0] mem_addr, mem_rdata, out_inst, out_pc, out_pc4;

  logic        mem_req_w, mem_ack_w, out_valid_w;
  logic [31:0] mem_addr_w, mem_rdata_w, out_inst_w, out_pc_w, out_pc4_w;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  assign mem_ack     = mem_req && (wait_cnt >= lat);
  assign mem_rdata   = mem_word(mem_addr);
  assign mem_ack_w   = mem_req_w;
  assign mem_rdata_w = mem_word(mem_addr_w);

  always @(posedge clk or posedge rst) begin
    if (rst)                       wait_cnt <= 0;
    else if (mem_req && !mem_ack)  wait_cnt <= wait_cnt + 1;
    else                           wait_cnt <= 0;
  end

  if_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .redirect(redirect),
    .redirect_pc(redirect_pc), .hold(hold), .out_valid(out_valid),
    .out_inst(out_inst), .out_pc(out_pc), .out_pc4(out_pc4)
  );

  if_fetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk(clk), .rst(rst), .mem_req(mem_req_w), .mem_addr(mem_addr_w),
    .mem_ack(mem_ack_w), .mem_rdata(mem_rdata_w), .redirect(1'b0),
    .redirect_pc(32'h0), .hold(1'b0), .out_valid(out_valid_w),
    .out_inst(out_inst_w), .out_pc(out_pc_w), .out_pc4(out_pc4_w)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("[%0t] FAIL %s: got %h expected %h", $time, tag, got, exp);
    end else begin
      $display("[%0t] ok   %s = %h", $time, tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    // Reset state
    check("rst mem_req", {31'b0, mem_req}, 32'd0);
    check("rst out_valid", {31'b0, out_valid}, 32'd0);
    check("rst mem_addr", mem_addr, 32'h0);
    check("rst out_inst", out_inst, 32'h0);
    check("rst out_pc4", out_pc4, 32'h0);

    // 1: zero-wait streaming
    lat = 0; hold = 1'b0;
    do_reset();
    step();
    check("t1 first req", {31'b0, mem_req}, 32'd1);
    check("t1 first addr", mem_addr, 32'h0);
    check("t1 no data yet", {31'b0, out_valid}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      step();
      check("t1 mem_addr", mem_addr, 32'(4 * (k + 1)));
      check("t1 out_valid", {31'b0, out_valid}, 32'd1);
      check("t1 out_pc", out_pc, 32'(4 * k));
      check("t1 out_inst", out_inst, mem_word(32'(4 * k)));
      check("t1 out_pc4", out_pc4, 32'(4 * k + 4));
    end

    // 2: hold fills exactly DEPTH entries, then drains in order
    lat = 0; hold = 1'b1;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      step();
      check("t2 fill addr", mem_addr, 32'(4 * k));
    end
    step();
    check("t2 req stops", {31'b0, mem_req}, 32'd0);
    check("t2 head pc", out_pc, 32'h0);
    for (int k = 0; k < 3; k++) begin
      step();
      check("t2 req idle", {31'b0, mem_req}, 32'd0);
    end
    hold = 1'b0;
    step();
    check("t2 pop pc", out_pc, 32'h4);
    check("t2 resume req", {31'b0, mem_req}, 32'd1);
    check("t2 resume addr", mem_addr, 32'h10);
    step();
    check("t2 pop pc", out_pc, 32'h8);
    step();
    check("t2 pop pc", out_pc, 32'hC);
    step();
    check("t2 pop pc", out_pc, 32'h10);
    check("t2 pop inst", out_inst, mem_word(32'h10));

    // 3: redirect during a 3-cycle wait -> DROP, stale word discarded
    lat = 3; hold = 1'b0;
    do_reset();
    step();
    check("t3 req addr", mem_addr, 32'h0);
    redirect = 1'b1; redirect_pc = 32'h40;
    step();
    redirect = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("t3 drop req", {31'b0, mem_req}, 32'd1);
      check("t3 drop addr", mem_addr, 32'h0);
      check("t3 drop valid", {31'b0, out_valid}, 32'd0);
      step();
    end
    check("t3 idle req", {31'b0, mem_req}, 32'd0);
    check("t3 stale dropped", {31'b0, out_valid}, 32'd0);
    step();
    check("t3 new addr", mem_addr, 32'h40);
    check("t3 new req", {31'b0, mem_req}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      check("t3 wait valid", {31'b0, out_valid}, 32'd0);
      step();
    end
    check("t3 valid", {31'b0, out_valid}, 32'd1);
    check("t3 pc", out_pc, 32'h40);
    check("t3 inst", out_inst, mem_word(32'h40));

    // 4: redirect on the ack cycle with the queue full (3 held + 1 outstanding)
    lat = 0; hold = 1'b1;
    do_reset();
    for (int k = 0; k < 4; k++) step();
    check("t4 pre addr", mem_addr, 32'hC);
    check("t4 pre head", out_pc, 32'h0);
    redirect = 1'b1; redirect_pc = 32'h102; hold = 1'b0;
    step();
    redirect = 1'b0;
    check("t4 flushed", {31'b0, out_valid}, 32'd0);
    check("t4 out_pc zero", out_pc, 32'h0);
    check("t4 req idle", {31'b0, mem_req}, 32'd0);
    step();
    check("t4 new addr", mem_addr, 32'h100);
    step();
    check("t4 valid", {31'b0, out_valid}, 32'd1);
    check("t4 pc", out_pc, 32'h100);

    // 5: PC wrap from RESET_PC = FFFF_FFF8
    do_reset();
    step();
    check("t5 addr", mem_addr_w, 32'hFFFF_FFF8);
    step();
    check("t5 pc", out_pc_w, 32'hFFFF_FFF8);
    check("t5 pc4", out_pc4_w, 32'hFFFF_FFFC);
    step();
    check("t5 pc", out_pc_w, 32'hFFFF_FFFC);
    check("t5 pc4 wrap", out_pc4_w, 32'h0);
    check("t5 inst", out_inst_w, mem_word(32'hFFFF_FFFC));
    step();
    check("t5 pc wrapped", out_pc_w, 32'h0);
    check("t5 pc4", out_pc4_w, 32'h4);

    // 6: asynchronous reset while a request is pending
    lat = 3; hold = 1'b1;
    do_reset();
    for (int k = 0; k < 6; k++) step();
    check("t6 pre valid", {31'b0, out_valid}, 32'd1);
    check("t6 pre req", {31'b0, mem_req}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("t6 async req", {31'b0, mem_req}, 32'd0);
    check("t6 async valid", {31'b0, out_valid}, 32'd0);
    check("t6 async inst", out_inst, 32'h0);
    check("t6 async addr", mem_addr, 32'h0);
    step();
    rst = 1'b0; hold = 1'b0; lat = 0;
    step();
    check("t6 restart req", {31'b0, mem_req}, 32'd1);
    check("t6 restart addr", mem_addr, 32'h0);
    step();
    check("t6 restart pc", out_pc, 32'h0);
    check("t6 restart valid", {31'b0, out_valid}, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
- Instruction-fetch front end that sits directly upstream of the pipeline's ID stage.
- Owns the fetch PC and issues word requests to an instruction memory with variable latency over a req/ack handshake.
- Buffers returned instructions, together with their PC and PC+4, in a small FIFO.
- Presents the FIFO head to ID, which can hold it with its stall signal. A branch or jump redirect flushes the queue and restarts fetch.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, 2..16.
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_req  out  1  instruction-memory request valid.
- mem_addr  out  32  request byte address; word aligned, bits [1:0] always 0.
- mem_ack  in  1  memory response valid; completes the current request.
- mem_rdata  in  32  instruction word, valid when mem_ack=1.
- redirect  in  1  taken branch or jump; flush and restart fetch.
- redirect_pc  in  32  new fetch address, sampled when redirect=1.
- hold  in  1  ID stall; the head entry is not consumed this cycle.
- out_valid  out  1  head entry valid.
- out_inst  out  32  head instruction; 32'h0 (NOP) when out_valid=0.
- out_pc  out  32  head PC; 0 when out_valid=0.
- out_pc4  out  32  head PC+4; 0 when out_valid=0.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, fetch_pc=RESET_PC, mem_addr=0, FIFO count=0.
  - mem_req=0, out_valid=0, out_inst/out_pc/out_pc4=0.
- FSM, with mem_req=1 exactly in states BUSY and DROP:
  - IDLE:
    - if redirect: fetch_pc<=redirect_pc, stay IDLE.
    - else if count_next<DEPTH: mem_addr<=fetch_pc, go BUSY.
  - BUSY, ack=1, redirect=0:
    - push {mem_rdata, mem_addr, mem_addr+4}; fetch_pc<=mem_addr+4.
    - if FIFO not full after push and pop: mem_addr<=mem_addr+4, stay BUSY (back-to-back, 1 instruction/cycle with zero-wait memory).
    - else go IDLE.
  - BUSY, ack=1, redirect=1: discard rdata, fetch_pc<=redirect_pc, go IDLE.
  - BUSY, ack=0, redirect=1: fetch_pc<=redirect_pc, go DROP. The request cannot be withdrawn, so mem_addr stays stable.
  - DROP: keep mem_req=1. On ack, discard rdata and go IDLE. A further redirect in DROP only updates fetch_pc.
- Handshake rules:
  - mem_addr is stable from the cycle mem_req rises until the ack cycle inclusive.
  - mem_req never drops without an ack.
  - At most one request is outstanding.
- FIFO:
  - pop = out_valid & ~hold & ~redirect.
  - push and pop in the same cycle are allowed, including when the FIFO is full (pop frees the slot) and when it is empty (the pushed entry appears next cycle).
  - Issue condition counts the outstanding slot, so a response is never dropped for lack of room.
- Redirect:
  - Highest priority. count<=0 on the same edge; any push or pop that cycle is suppressed.
  - out_valid=0 the next cycle.
- Latency:
  - Reset release to first mem_req: 1 cycle.
  - ack to out_valid: 1 cycle.
  - redirect to the new address on mem_req: 2 cycles from IDLE or BUSY; DROP adds one cycle per extra ack-wait cycle.
- Arithmetic: PC adds are 32-bit and wrap modulo 2^32 (32'hFFFF_FFFC+4 = 0). redirect_pc[1:0] is forced to 0.
- Outputs are driven from the FIFO head register with no combinational path from mem_rdata, so the block drops into the existing IF/ID register position.

Decomposition:
- Shared header fetch_defs.v holds:
  - FSM state codes: IDLE=2'd0, BUSY=2'd1, DROP=2'd2.
  - NOP_INST=32'h0.
  - entry width 96 = {inst, pc, pc4}.
- One sub-module, fq_fifo: synchronous DEPTH x 96 FIFO with push, pop, flush, count, full, empty and async reset, built on circular read/write pointers.
- The FSM and PC logic stay in the top module.

Test Plan:
1. Reset release, zero-wait memory (ack the same cycle as req), hold=0 → mem_addr 0,4,8,… one per cycle; out_pc 0,4,8 with out_inst matching memory; out_pc4=out_pc+4.
2. hold=1 permanently, zero-wait memory → exactly DEPTH=4 entries fetched, then mem_req=0; release hold → entries pop in order PC 0,4,8,C, then fetch resumes at 0x10.
3. Memory with 3-cycle ack latency, redirect to 0x40 in the first wait cycle → DROP; the stale response is discarded; the next request is to 0x40; out_valid=0 until the 0x40 entry arrives.
4. redirect to 0x100 in the same cycle as ack, with a full FIFO and hold=0 → no pop and no push; count=0 next cycle; next request to 0x100.
5. Fetch starting at RESET_PC=32'hFFFF_FFF8 → PCs FFFF_FFF8, FFFF_FFFC, 0000_0000; out_pc4 of the FFFF_FFFC entry is 0.
6. rst asserted mid-request (BUSY, ack pending) → mem_req=0, out_valid=0 immediately without waiting for a clock edge; after release, fetch restarts at RESET_PC.
